instr_fetch_buf: RTL and testbench

- Instruction fetch front end. Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched 8-bit instruction codes in a small prefetch FIFO and presents them to the IF/ID pipeline register with a valid/stall handshake.
- Supports flush/redirect to a new PC and stops fetching on a halt code.
- Sits directly upstream of the ifid stage and supplies its instr_code input.

---
 rtl/instr_fetch_buf_pkg.sv | 28 ++
 rtl/instr_fetch_buf_sync_fifo.sv | 94 +++++++++
 rtl/instr_fetch_buf.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_buf.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buf_pkg
// Purpose  : Shared constants and the fetch entry type for the instruction
//            fetch front end (instr_fetch_buf and its prefetch queue).
// Contents : PC_W      - default program counter / imem address width
//            CODE_W    - instruction code width
//            HALT_CODE - code that ends fetching
//            NOP_CODE  - code presented when no instruction is held
//            instr_entry_t - {code, pc} pair at the default widths
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_buf_pkg;

   localparam int PC_W   = 8;
   localparam int CODE_W = 8;

   localparam logic [CODE_W-1:0] HALT_CODE = 8'hFF;
   localparam logic [CODE_W-1:0] NOP_CODE  = 8'h00;

   // One prefetched instruction together with the address it came from.
   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [PC_W-1:0]   pc;
   } instr_entry_t;

endpackage : instr_fetch_buf_pkg
`default_nettype wire

// File: rtl/instr_fetch_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Small synchronous FIFO with a registered head. Used as the
//            prefetch queue of instr_fetch_buf.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset
//            clear     - synchronous flush of all entries (wins over push/pop)
//            push      - write push_data at the tail
//            push_data - entry to write
//            pop       - drop the head entry (ignored when empty)
//            pop_data  - current head entry (valid when empty=0)
//            count     - number of entries held
//            full      - count == DEPTH
//            empty     - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_CNT);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A push into a full queue is accepted only when the head leaves in the
   // same cycle; DEPTH is a power of two so the pointers wrap naturally.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   // Storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buf
// Purpose  : Instruction fetch front end. Owns the PC, reads a synchronous
//            instruction memory (1-cycle latency), buffers codes in a
//            prefetch queue and hands them to IF/ID with valid/stall.
// Ports    : clk         - clock, rising edge
//            rst         - asynchronous active-low reset
//            stall       - downstream not ready, hold the head entry
//            flush       - redirect fetch to flush_pc
//            flush_pc    - redirect target
//            imem_addr   - instruction memory read address (= pc)
//            imem_en     - read request this cycle
//            imem_rdata  - read data, valid the cycle after imem_en
//            instr_code  - head instruction, NOP_CODE when not valid
//            instr_valid - instr_code holds a real instruction
//            instr_pc    - address of the head instruction, 0 when not valid
//            halted      - the halt instruction has been consumed downstream
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buf #(
   parameter int PC_W       = instr_fetch_buf_pkg::PC_W,
   parameter int FIFO_DEPTH = 2,
   parameter logic [instr_fetch_buf_pkg::CODE_W-1:0] HALT_CODE = instr_fetch_buf_pkg::HALT_CODE,
   parameter logic [instr_fetch_buf_pkg::CODE_W-1:0] NOP_CODE  = instr_fetch_buf_pkg::NOP_CODE
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   stall,
   input  logic                                   flush,
   input  logic [PC_W-1:0]                        flush_pc,
   output logic [PC_W-1:0]                        imem_addr,
   output logic                                   imem_en,
   input  logic [instr_fetch_buf_pkg::CODE_W-1:0] imem_rdata,
   output logic [instr_fetch_buf_pkg::CODE_W-1:0] instr_code,
   output logic                                   instr_valid,
   output logic [PC_W-1:0]                        instr_pc,
   output logic                                   halted
);

   import instr_fetch_buf_pkg::*;

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = CODE_W + PC_W;
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

   // Same layout as instr_entry_t, sized by this instance's PC_W.
   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;

   logic [PC_W-1:0] pc_q,         pc_d;
   logic            pending_q,    pending_d;
   logic [PC_W-1:0] pend_addr_q,  pend_addr_d;
   logic            fetch_stop_q, fetch_stop_d;
   logic            halted_q,     halted_d;

   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             credit_ok;

   assign instr_valid = ~fifo_empty;

   // Flush overrides a same-cycle pop and push.
   assign pop  = instr_valid & ~stall & ~flush;
   assign push = pending_q & ~fetch_stop_q & ~flush;

   // Credit: queued + in-flight entries, less the one leaving now, must stay
   // below the depth. Written as an addition on the right to avoid underflow.
   assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q})
                      < (DEPTH_LIM + {{CNT_W{1'b0}}, pop});

   // rst gates the request so the memory sees no read while reset is held.
   assign imem_en   = rst & ~fetch_stop_q & ~flush & credit_ok;
   assign imem_addr = pc_q;

   assign push_entry.code = imem_rdata;
   assign push_entry.pc   = pend_addr_q;

   always_comb begin
      pc_d         = pc_q;
      pending_d    = imem_en;
      pend_addr_d  = imem_en ? pc_q : pend_addr_q;
      fetch_stop_d = fetch_stop_q;
      halted_d     = halted_q;
      if (flush) begin
         pc_d         = flush_pc;
         fetch_stop_d = 1'b0;
         halted_d     = 1'b0;
      end else begin
         if (imem_en) begin
            pc_d = pc_q + PC_W'(1);
         end
         // Stopping on the push edge means a read issued alongside the halt
         // returns while fetch_stop is set and is therefore dropped.
         if (push && (imem_rdata == HALT_CODE)) begin
            fetch_stop_d = 1'b1;
         end
         if (pop && (head.code == HALT_CODE)) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= '0;
         pending_q    <= 1'b0;
         pend_addr_q  <= '0;
         fetch_stop_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         pend_addr_q  <= pend_addr_d;
         fetch_stop_q <= fetch_stop_d;
         halted_q     <= halted_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_prefetch_q (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign instr_code = instr_valid ? head.code : NOP_CODE;
   assign instr_pc   = instr_valid ? head.pc   : '0;
   assign halted     = halted_q;

   // The credit rule must make overflow impossible.
   a_no_fifo_overflow: assert property (
      @(posedge clk) disable iff (!rst) !(push && fifo_full && !pop)
   );

endmodule : instr_fetch_buf
`default_nettype wire

// File: tb/tb_instr_fetch_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_buf
// Purpose  : Self-checking bench for instr_fetch_buf. Stimulus queues the
//            hand-computed instruction stream; a negedge monitor compares
//            every presented instruction against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buf;

   typedef struct packed {
      logic [7:0] code;
      logic [7:0] pc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       flush;
   logic [7:0] flush_pc;
   logic [7:0] imem_addr;
   logic       imem_en;
   logic [7:0] imem_rdata = 8'h00;
   logic [7:0] instr_code;
   logic       instr_valid;
   logic [7:0] instr_pc;
   logic       halted;

   always #5 clk = ~clk;

   instr_fetch_buf #(
      .PC_W       (8),
      .FIFO_DEPTH (2),
      .HALT_CODE  (8'hFF),
      .NOP_CODE   (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .imem_rdata  (imem_rdata),
      .instr_code  (instr_code),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .halted      (halted)
   );

   // Synchronous instruction memory, 1-cycle read latency.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   prev_flush = 1'b0;
   bit   model_halted = 1'b0;
   bit   chk_en0 = 1'b0;
   bit   chk_drained = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("rst_imem_en",     int'(imem_en), 0);
         chk("rst_imem_addr",   int'(imem_addr), 0);
         chk("rst_instr_valid", int'(instr_valid), 0);
         chk("rst_instr_code",  int'(instr_code), 0);
         chk("rst_instr_pc",    int'(instr_pc), 0);
         chk("rst_halted",      int'(halted), 0);
         cyc          = 0;
         model_halted = 1'b0;
         prev_flush   = 1'b0;
      end else begin
         if (cyc < 1000) cyc = cyc + 1;
         chk("halted", int'(halted), int'(model_halted));
         if (cyc == 1) begin
            chk("first_imem_en",   int'(imem_en), 1);
            chk("first_imem_addr", int'(imem_addr), 0);
         end
         if (cyc == 2) chk("latency_not_yet", int'(instr_valid), 0);
         if (cyc == 3) chk("latency_valid", int'(instr_valid), 1);
         if (prev_flush) chk("post_flush_valid", int'(instr_valid), 0);
         if (flush) chk("flush_imem_en", int'(imem_en), 0);
         if (chk_en0) chk("imem_en_idle", int'(imem_en), 0);
         if (chk_drained) chk("queue_drained", q.size(), 0);
         if (instr_valid && !flush) begin
            chk("instr_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q[0];
               chk("instr_code", int'(instr_code), int'(e.code));
               chk("instr_pc",   int'(instr_pc),   int'(e.pc));
               if (!stall) begin
                  void'(q.pop_front());
                  if (e.code == 8'hFF) model_halted = 1'b1;
               end
            end
         end else if (!instr_valid) begin
            chk("idle_code", int'(instr_code), 0);
            chk("idle_pc",   int'(instr_pc), 0);
         end
         if (flush) model_halted = 1'b0;
         prev_flush = flush;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [7:0] c, input logic [7:0] p);
      exp_t e;
      e.code = c;
      e.pc   = p;
      q.push_back(e);
   endtask

   task automatic exp_run_from_zero();
      exp_push(8'h11, 8'h00);
      exp_push(8'h22, 8'h01);
      exp_push(8'h33, 8'h02);
      exp_push(8'h44, 8'h03);
      exp_push(8'hFF, 8'h04);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
      mem[8'h03] = 8'h44; mem[8'h04] = 8'hFF; mem[8'h05] = 8'h55;
      mem[8'h40] = 8'hA0; mem[8'h41] = 8'hA1; mem[8'h42] = 8'hA2;
      for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'hC0 + 8'(i);
      mem[8'h84] = 8'hFF; mem[8'h85] = 8'hC5;
      mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'hE1;
      for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'h50 + 8'(i);

      // Run from reset, stall mid-stream, stop on halt at address 4.
      exp_run_from_zero();
      step(3); rst = 1'b1;
      step(3); stall = 1'b1;
      step(2); chk_en0 = 1'b1;
      step(3); stall = 1'b0; chk_en0 = 1'b0;
      step(6); chk_en0 = 1'b1;
      step(4); chk_en0 = 1'b0; chk_drained = 1'b1;
      step(1); chk_drained = 1'b0;

      // Fill under stall from 0x40, then redirect to 0x80 with a read in flight.
      stall = 1'b1; flush = 1'b1; flush_pc = 8'h40; q.delete();
      step(1); flush = 1'b0;
      step(2); flush = 1'b1; flush_pc = 8'h80; q.delete();
      for (int i = 0; i < 4; i++) exp_push(8'hC0 + 8'(i), 8'h80 + 8'(i));
      exp_push(8'hFF, 8'h84);
      step(1); flush = 1'b0; stall = 1'b0;
      step(14); chk_en0 = 1'b1;
      step(2); chk_en0 = 1'b0; chk_drained = 1'b1;
      step(1); chk_drained = 1'b0;

      // PC wrap from 0xFE.
      flush = 1'b1; flush_pc = 8'hFE;
      exp_push(8'hE0, 8'hFE);
      exp_push(8'hE1, 8'hFF);
      exp_run_from_zero();
      step(1); flush = 1'b0;
      step(16); chk_drained = 1'b1;
      step(1); chk_drained = 1'b0;

      // Asynchronous reset between edges mid-stream, then restart from 0.
      flush = 1'b1; flush_pc = 8'h10;
      for (int i = 0; i < 8; i++) exp_push(8'h50 + 8'(i), 8'h10 + 8'(i));
      step(1); flush = 1'b0;
      step(4); #2; rst = 1'b0; q.delete();
      step(2); exp_run_from_zero(); rst = 1'b1;
      step(15); chk_drained = 1'b1;
      step(1); chk_drained = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_instr_fetch_buf
`default_nettype wire
